// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network datapath stages.
// Holds default operand widths, the forward-pass FSM state encoding and the
// unsigned saturating adder used by the accumulators.
package nn_pkg;

  localparam int HW    = 10;  // hidden activation width
  localparam int WW    = 8;   // weight width
  localparam int ACC_W = 19;  // accumulator / output width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Unsigned add clamped to 2^w-1. Callers keep both operands below 2^w
  // (w < 63), so the 64-bit sum itself can never wrap.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] max_v;
    logic [63:0] s;
    max_v = (64'd1 << w) - 64'd1;
    s     = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

endpackage

// File: rtl/weight_bank.sv
// Output-neuron weight register bank.
// Ports: clk_i/rst_i (async active-low), clr_i sync clear to W_INIT (wins over
// a write), one write port (wr_*), two combinational read ports (rd0_*, rd1_*).
module weight_bank #(
  parameter int              N      = 2,
  parameter int              WW     = 8,
  parameter int              IW     = 1,
  parameter logic [WW-1:0]   W_INIT = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [WW-1:0] wr_data_i,
  input  logic [IW-1:0] rd0_idx_i,
  output logic [WW-1:0] rd0_o,
  input  logic [IW-1:0] rd1_idx_i,
  output logic [WW-1:0] rd1_o
);

  logic [WW-1:0] w_q [N];
  logic [WW-1:0] w_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_d[i] = w_q[i];
      if (clr_i) begin
        w_d[i] = W_INIT;
      end else if (wr_en_i && (int'(wr_idx_i) == i)) begin
        w_d[i] = wr_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) w_q[i] <= W_INIT;
    end else begin
      for (int i = 0; i < N; i++) w_q[i] <= w_d[i];
    end
  end

  // Reads see the registered contents only, so a read of an index being
  // written this cycle returns the old value. Out-of-range indices (N not a
  // power of two) read as W_INIT.
  assign rd0_o = (int'(rd0_idx_i) < N) ? w_q[rd0_idx_i] : W_INIT;
  assign rd1_o = (int'(rd1_idx_i) < N) ? w_q[rd1_idx_i] : W_INIT;

endmodule

// File: rtl/output_forward.sv
// Output-layer forward pass: sequential saturating MAC of hidden activations
// against the weight bank; result registered on final_o with a done_o pulse.
// Ports: start_i/busy_o/done_o handshake, hid_idx_o/hidden_val_i activation
// fetch, w_wr_* + zero_weight_reset_i bank update, w_rd_o bank read-back.
module output_forward #(
  parameter int                  N_HIDDEN = 2,
  parameter int                  HW       = nn_pkg::HW,
  parameter int                  WW       = nn_pkg::WW,
  parameter int                  ACC_W    = nn_pkg::ACC_W,
  parameter logic [WW-1:0]       W_INIT   = '0,
  localparam int                 IW       = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic [IW-1:0]    hid_idx_o,
  input  logic [HW-1:0]    hidden_val_i,
  input  logic             w_wr_en_i,
  input  logic [IW-1:0]    w_wr_idx_i,
  input  logic [WW-1:0]    w_wr_data_i,
  output logic [WW-1:0]    w_rd_o,
  input  logic             zero_weight_reset_i,
  output logic [ACC_W-1:0] final_o,
  output logic             busy_o,
  output logic             done_o
);

  import nn_pkg::*;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] final_q, final_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WW-1:0]    w_mac;
  logic [HW+WW-1:0] prod;
  logic [ACC_W-1:0] mac_sum;

  weight_bank #(
    .N      (N_HIDDEN),
    .WW     (WW),
    .IW     (IW),
    .W_INIT (W_INIT)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (zero_weight_reset_i),
    .wr_en_i   (w_wr_en_i),
    .wr_idx_i  (w_wr_idx_i),
    .wr_data_i (w_wr_data_i),
    .rd0_idx_i (hid_idx_o),
    .rd0_o     (w_mac),
    .rd1_idx_i (w_wr_idx_i),
    .rd1_o     (w_rd_o)
  );

  assign prod    = (HW+WW)'(hidden_val_i) * (HW+WW)'(w_mac);
  assign mac_sum = ACC_W'(sat_add(64'(acc_q), 64'(prod), ACC_W));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    final_d = final_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          acc_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d  = mac_sum;
        busy_d = 1'b1;
        if (idx_q == IW'(N_HIDDEN - 1)) begin
          // Load final_o on the last MAC edge so it is already valid in the
          // DONE cycle alongside the done_o pulse.
          final_d = mac_sum;
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      final_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      final_q <= final_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign hid_idx_o = (state_q == MAC) ? idx_q : '0;
  assign final_o   = final_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_output_forward.sv
// Directed bench for output_forward: a 2-input instance for most scenarios
// and a 3-input instance for the saturation case.
module tb_output_forward;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // ---------------- N_HIDDEN = 2 instance ----------------
  logic        start2;
  logic [0:0]  hid_idx2;
  logic [9:0]  hidden_val2;
  logic        w_en2;
  logic [0:0]  w_idx2;
  logic [7:0]  w_dat2;
  logic [7:0]  w_rd2;
  logic        zwr2;
  logic [18:0] final2;
  logic        busy2;
  logic        done2;
  logic [9:0]  hid2 [0:1];

  // ---------------- N_HIDDEN = 3 instance ----------------
  logic        start3;
  logic [1:0]  hid_idx3;
  logic [9:0]  hidden_val3;
  logic        w_en3;
  logic [1:0]  w_idx3;
  logic [7:0]  w_dat3;
  logic [7:0]  w_rd3;
  logic        zwr3;
  logic [18:0] final3;
  logic        busy3;
  logic        done3;
  logic [9:0]  hid3 [0:2];

  output_forward #(.N_HIDDEN(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start2), .hid_idx_o(hid_idx2),
    .hidden_val_i(hidden_val2), .w_wr_en_i(w_en2), .w_wr_idx_i(w_idx2),
    .w_wr_data_i(w_dat2), .w_rd_o(w_rd2), .zero_weight_reset_i(zwr2),
    .final_o(final2), .busy_o(busy2), .done_o(done2)
  );

  output_forward #(.N_HIDDEN(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start3), .hid_idx_o(hid_idx3),
    .hidden_val_i(hidden_val3), .w_wr_en_i(w_en3), .w_wr_idx_i(w_idx3),
    .w_wr_data_i(w_dat3), .w_rd_o(w_rd3), .zero_weight_reset_i(zwr3),
    .final_o(final3), .busy_o(busy3), .done_o(done3)
  );

  always_comb hidden_val2 = hid2[hid_idx2];
  always_comb hidden_val3 = (hid_idx3 < 2'd3) ? hid3[hid_idx3] : 10'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w2(input logic [0:0] idx, input logic [7:0] dat);
    w_en2 = 1'b1; w_idx2 = idx; w_dat2 = dat;
    step();
    w_en2 = 1'b0;
  endtask

  task automatic write_w3(input logic [1:0] idx, input logic [7:0] dat);
    w_en3 = 1'b1; w_idx3 = idx; w_dat3 = dat;
    step();
    w_en3 = 1'b0;
  endtask

  // Pulse start, then count cycles until done_o (1 = first MAC cycle).
  // lat stays -1 if done_o never shows within the budget.
  task automatic run_pass2(output logic [18:0] res, output int lat);
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done2) begin
        lat = i;
        res = final2;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic run_pass3(output logic [18:0] res, output int lat);
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    lat = -1;
    res = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done3) begin
        lat = i;
        res = final3;
        step();
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    @(negedge clk);
    checks++; if (final2 !== 19'd0) begin errors++; $display("FAIL reset_final got %0d exp 0", final2); end
    checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy2); end
    checks++; if (hid_idx2 !== 1'b0) begin errors++; $display("FAIL reset_hid_idx got %0d exp 0", hid_idx2); end
    checks++; if (w_rd2 !== 8'd0) begin errors++; $display("FAIL reset_w_rd got %0d exp 0", w_rd2); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    write_w2(1'b0, 8'd3);
    write_w2(1'b1, 8'd5);
    hid2[0] = 10'd100; hid2[1] = 10'd200;
    w_idx2 = 1'b1;
    @(negedge clk);
    checks++; if (w_rd2 !== 8'd5) begin errors++; $display("FAIL basic_w_rd got %0d exp 5", w_rd2); end
    step();
    start2 = 1'b1;
    step();                      // start sampled; first MAC cycle
    start2 = 1'b0;
    @(negedge clk);
    checks++; if (busy2 !== 1'b1 || hid_idx2 !== 1'b0 || done2 !== 1'b0) begin
      errors++; $display("FAIL basic_mac0 got busy=%0b idx=%0d done=%0b exp busy=1 idx=0 done=0", busy2, hid_idx2, done2);
    end
    step();
    @(negedge clk);
    checks++; if (busy2 !== 1'b1 || hid_idx2 !== 1'b1 || done2 !== 1'b0) begin
      errors++; $display("FAIL basic_mac1 got busy=%0b idx=%0d done=%0b exp busy=1 idx=1 done=0", busy2, hid_idx2, done2);
    end
    step();
    @(negedge clk);
    checks++; if (done2 !== 1'b1 || busy2 !== 1'b1 || hid_idx2 !== 1'b0) begin
      errors++; $display("FAIL basic_done got done=%0b busy=%0b idx=%0d exp done=1 busy=1 idx=0", done2, busy2, hid_idx2);
    end
    checks++; if (final2 !== 19'd1300) begin errors++; $display("FAIL basic_final got %0d exp 1300", final2); end
    step();
    @(negedge clk);
    checks++; if (done2 !== 1'b0 || busy2 !== 1'b0 || final2 !== 19'd1300) begin
      errors++; $display("FAIL basic_idle got done=%0b busy=%0b final=%0d exp 0 0 1300", done2, busy2, final2);
    end
    step();
  endtask

  task automatic test_max_in_range();
    logic [18:0] res;
    int          lat;
    write_w2(1'b0, 8'd255);
    write_w2(1'b1, 8'd255);
    hid2[0] = 10'd1023; hid2[1] = 10'd1023;
    run_pass2(res, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL max_latency got %0d exp 3", lat); end
    checks++; if (res !== 19'd521730) begin errors++; $display("FAIL max_final got %0d exp 521730", res); end
  endtask

  task automatic test_saturation();
    logic [18:0] res;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      write_w3(2'(i), 8'd255);
      hid3[i] = 10'd1023;
    end
    run_pass3(res, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL sat_latency got %0d exp 4", lat); end
    checks++; if (res !== 19'd524287) begin errors++; $display("FAIL sat_final got %0d exp 524287", res); end
  endtask

  task automatic test_write_collision();
    logic [18:0] res;
    int          lat;
    write_w2(1'b0, 8'd3);
    write_w2(1'b1, 8'd5);
    hid2[0] = 10'd10; hid2[1] = 10'd10;
    // IDLE cycle: start plus a write to a weight the pass has not used yet
    start2 = 1'b1; w_en2 = 1'b1; w_idx2 = 1'b1; w_dat2 = 8'd7;
    step();
    // MAC idx 0: overwrite the weight being read this very cycle
    start2 = 1'b0; w_en2 = 1'b1; w_idx2 = 1'b0; w_dat2 = 8'd9;
    @(negedge clk);
    checks++; if (hid_idx2 !== 1'b0) begin errors++; $display("FAIL coll_idx0 got %0d exp 0", hid_idx2); end
    step();
    w_en2 = 1'b0;
    step();
    @(negedge clk);
    checks++; if (done2 !== 1'b1 || final2 !== 19'd100) begin
      errors++; $display("FAIL coll_final got done=%0b final=%0d exp done=1 final=100", done2, final2);
    end
    step();
    run_pass2(res, lat);
    checks++; if (res !== 19'd160 || lat !== 3) begin
      errors++; $display("FAIL coll_next got final=%0d lat=%0d exp 160 3", res, lat);
    end
  endtask

  task automatic test_start_held();
    int ndone;
    int first;
    int second;
    ndone = 0; first = -1; second = -1;
    start2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done2) begin
        ndone++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      step();
    end
    start2 = 1'b0;
    step();
    checks++; if (ndone !== 3) begin errors++; $display("FAIL held_count got %0d exp 3", ndone); end
    checks++; if (first !== 3 || second !== 7) begin
      errors++; $display("FAIL held_spacing got %0d,%0d exp 3,7", first, second);
    end
    checks++; if (final2 !== 19'd160) begin errors++; $display("FAIL held_final got %0d exp 160", final2); end
  endtask

  task automatic test_async_reset();
    logic [18:0] res;
    int          lat;
    int          seen_done;
    write_w2(1'b0, 8'd3);
    write_w2(1'b1, 8'd5);
    hid2[0] = 10'd100; hid2[1] = 10'd200;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();                      // MAC idx 1
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || hid_idx2 !== 1'b0 || final2 !== 19'd0) begin
      errors++; $display("FAIL arst_now got busy=%0b done=%0b idx=%0d final=%0d exp all 0", busy2, done2, hid_idx2, final2);
    end
    w_idx2 = 1'b1;
    #1;
    checks++; if (w_rd2 !== 8'd0) begin errors++; $display("FAIL arst_weight got %0d exp 0", w_rd2); end
    seen_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done2) seen_done++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done2) seen_done++;
      step();
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL arst_no_done got %0d exp 0", seen_done); end
    run_pass2(res, lat);
    checks++; if (res !== 19'd0 || lat !== 3) begin
      errors++; $display("FAIL arst_pass got final=%0d lat=%0d exp 0 3", res, lat);
    end
  endtask

  task automatic test_zero_weight_reset();
    logic [18:0] res;
    int          lat;
    write_w2(1'b0, 8'd3);
    write_w2(1'b1, 8'd5);
    run_pass2(res, lat);
    checks++; if (res !== 19'd1300) begin errors++; $display("FAIL zwr_pre got %0d exp 1300", res); end
    // clear and write in the same cycle: clear wins
    zwr2 = 1'b1; w_en2 = 1'b1; w_idx2 = 1'b0; w_dat2 = 8'd200;
    step();
    zwr2 = 1'b0; w_en2 = 1'b0;
    @(negedge clk);
    checks++; if (w_rd2 !== 8'd0) begin errors++; $display("FAIL zwr_w0 got %0d exp 0", w_rd2); end
    checks++; if (final2 !== 19'd1300) begin errors++; $display("FAIL zwr_final_kept got %0d exp 1300", final2); end
    w_idx2 = 1'b1;
    #1;
    checks++; if (w_rd2 !== 8'd0) begin errors++; $display("FAIL zwr_w1 got %0d exp 0", w_rd2); end
    step();
    run_pass2(res, lat);
    checks++; if (res !== 19'd0) begin errors++; $display("FAIL zwr_pass got %0d exp 0", res); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    start2 = 1'b0; w_en2 = 1'b0; w_idx2 = '0; w_dat2 = '0; zwr2 = 1'b0;
    start3 = 1'b0; w_en3 = 1'b0; w_idx3 = '0; w_dat3 = '0; zwr3 = 1'b0;
    hid2[0] = '0; hid2[1] = '0;
    for (int i = 0; i < 3; i++) hid3[i] = '0;
    test_reset();
    test_basic();
    test_max_in_range();
    test_saturation();
    test_write_collision();
    test_start_held();
    test_async_reset();
    test_zero_weight_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/output_forward.md
# output_forward

Output-layer forward-pass stage. Holds the output-neuron weight bank and runs a sequential multiply-accumulate over the hidden-layer activations to produce the 19-bit network output. The 19-bit output feeds the output backpropagation stage as its network-output operand. The weight bank is written back by that stage with updated weights, and its read port supplies that stage's current-weight operand.

## Interface
Parameters:
- N_HIDDEN, 2, number of hidden activations and weights (≥2)
- HW, 10, hidden activation width (unsigned)
- WW, 8, weight width (unsigned)
- ACC_W, 19, accumulator and output width
- W_INIT, 0, reset and clear value of every weight

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  request a forward pass; sampled only in IDLE
- hid_idx_o  out  IW=max(1,clog2(N_HIDDEN))  index of the hidden activation requested this cycle
- hidden_val_i  in  HW  activation for hid_idx_o; combinational response, same cycle
- w_wr_en_i  in  1  weight write strobe
- w_wr_idx_i  in  IW  weight write/read index
- w_wr_data_i  in  WW  new weight value
- w_rd_o  out  WW  combinational read of weight[w_wr_idx_i]; drives the backprop stage's weight operand
- zero_weight_reset_i  in  1  synchronous clear of all weights to W_INIT
- final_o  out  ACC_W  registered result of the last completed pass
- busy_o  out  1  high in MAC and DONE
- done_o  out  1  one-cycle pulse: final_o has just been updated

## Operation
- FSM states and transitions:
  - IDLE: start_i=1 clears acc, sets idx=0, moves to MAC.
  - MAC: each cycle performs acc ← sat(acc + hidden_val_i × weight[idx]), then idx++. At idx=N_HIDDEN-1 the FSM moves to DONE.
  - DONE: final_o ← acc, done_o=1, moves to IDLE.
- Arithmetic is unsigned. The product width is HW+WW and is zero-extended to ACC_W+1. If the sum exceeds 2^ACC_W−1, acc saturates to all-ones. Saturation never wraps.
- hid_idx_o equals idx in MAC. It is 0 in IDLE and DONE.
- start_i in MAC or DONE is ignored and not queued.
- Weight writes:
  - Accepted in any state.
  - Take effect at the next edge.
  - A MAC read of the same index in the same cycle uses the old value.
  - A write to an index not yet consumed in the current pass is used by that pass.
- zero_weight_reset_i clears all weights to W_INIT at the next edge and overrides a simultaneous write. It does not abort a running pass; subsequent MAC cycles see the cleared weights. It does not alter final_o.
- Asynchronous reset (rst_i=0) forces the following immediately, including mid-pass, with no output from the aborted pass:
  - state IDLE, idx 0, acc 0
  - final_o 0, done_o 0, busy_o 0
  - all weights W_INIT

## Timing
- Reset values: final_o=0, done_o=0, busy_o=0, hid_idx_o=0, w_rd_o=W_INIT.
- With start_i sampled at edge k:
  - MAC occupies cycles k+1 … k+N_HIDDEN.
  - done_o is high and final_o is valid in cycle k+N_HIDDEN+1.
  - Latency is N_HIDDEN+1 cycles.
- The earliest next start is sampled in the cycle after done_o, giving a pass period of N_HIDDEN+2 cycles.
- final_o holds until the next done_o.
- w_rd_o is purely combinational from the bank registers and w_wr_idx_i.

## Structure
- Shared package nn_pkg holds:
  - width constants HW, WW, ACC_W
  - state enum {IDLE, MAC, DONE}
  - the saturating-add function
- Sub-module weight_bank holds the N_HIDDEN×WW registers. It has:
  - async reset
  - sync clear
  - one write port
  - two combinational read ports: MAC index and w_wr_idx_i
- The top level holds the FSM, idx counter, accumulator and final_o register.

## Test plan
- Basic pass: weights {3,5}, hidden {100,200}, start → done_o 3 cycles later, final_o=1300, busy_o high for 2+1 cycles.
- Maximum in range: weights {255,255}, hidden {1023,1023} → final_o=521730, no saturation.
- Saturation (N_HIDDEN=3, all weights 255, all hidden 1023) → sum 782595 clamps to final_o=524287.
- Write collision: during MAC idx=0, write weight[0]=9 (old 3) and weight[1]=7 (old 5); hidden {10,10} → final_o=30+70=100; the next pass uses 9 → 160.
- Control hazards: start_i held high through the pass → exactly one done_o per N_HIDDEN+2 cycles. zero_weight_reset_i together with w_wr_en_i → weight stays W_INIT.
- Async reset mid-MAC: drop rst_i at idx=1 → outputs zero immediately, no done_o. After release, start with weights W_INIT=0 → final_o=0.
